// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the router synchronizer
package router_pkg;
    localparam int NUM_CH          = 3;
    localparam int ADDR_W          = 2;
    localparam int TIMEOUT_DEFAULT = 30;

    typedef logic [ADDR_W-1:0] ch_addr_t;

    localparam ch_addr_t ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer: per-channel unread-data watchdog producing a one-cycle soft reset
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    logic [CNT_W-1:0] cnt;

    // Count consecutive unread-valid cycles; pulse and restart when the limit is reached
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end
endmodule

// File: rtl/router_sync.sv
// router_sync: steers FSM writes to the addressed FIFO and watches each channel for stale data
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        detect_add,
    input  logic [1:0]  data_in,
    input  logic        write_enb_reg,
    input  logic        read_enb_0,
    input  logic        read_enb_1,
    input  logic        read_enb_2,
    input  logic        empty_0,
    input  logic        empty_1,
    input  logic        empty_2,
    input  logic        full_0,
    input  logic        full_1,
    input  logic        full_2,
    output logic [2:0]  write_enb,
    output logic        fifo_full,
    output logic        vld_out_0,
    output logic        vld_out_1,
    output logic        vld_out_2,
    output logic        soft_reset_0,
    output logic        soft_reset_1,
    output logic        soft_reset_2
);
    ch_addr_t          addr_q;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] sr;
    logic [3:0]        full_x;

    // Capture the header destination; it stays valid until the next header
    always_ff @(posedge clock) begin
        if (!resetn)
            addr_q <= ADDR_INVALID;
        else if (detect_add)
            addr_q <= data_in;
    end

    // Decode the write strobe and select the addressed full flag; address 3 maps to nothing
    always_comb begin
        full_x    = {1'b0, full_2, full_1, full_0};
        write_enb = write_enb_reg ? (3'b001 << addr_q) : 3'b000;
        fifo_full = full_x[addr_q];
    end

    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0    = vld[0];
    assign vld_out_1    = vld[1];
    assign vld_out_2    = vld[2];
    assign soft_reset_0 = sr[0];
    assign soft_reset_1 = sr[1];
    assign soft_reset_2 = sr[2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_timer
        router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (vld[i]),
            .rd         (rd[i]),
            .soft_reset (sr[i])
        );
    end
endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: randomized and directed checks of router_sync against a behavioural model
module tb_router_sync;
    localparam int TO = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] rd;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int tests_run = 0;
    int fails = 0;

    int         m_addr;
    int         run [3];
    logic [2:0] exp_sr;

    always #5 clock = ~clock;

    router_sync #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (rd[0]),
        .read_enb_1    (rd[1]),
        .read_enb_2    (rd[2]),
        .empty_0       (empty[0]),
        .empty_1       (empty[1]),
        .empty_2       (empty[2]),
        .full_0        (full[0]),
        .full_1        (full[1]),
        .full_2        (full[2]),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    // Reference model: run length of consecutive unread-valid edges; a pulse follows every TO-th one
    always @(posedge clock) begin
        if (!resetn) begin
            m_addr = 3;
            exp_sr = 3'b000;
            for (int i = 0; i < 3; i++) run[i] = 0;
        end else begin
            if (detect_add) m_addr = int'(data_in);
            for (int i = 0; i < 3; i++) begin
                if (!empty[i] && !rd[i]) begin
                    run[i]++;
                    exp_sr[i] = (run[i] % TO == 0);
                end else begin
                    run[i] = 0;
                    exp_sr[i] = 1'b0;
                end
            end
        end
    end

    function automatic logic [9:0] expv();
        logic [2:0] we;
        logic       ff;
        we = (write_enb_reg && m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
        ff = (m_addr < 3) ? full[m_addr] : 1'b0;
        return {we, ff, ~empty, exp_sr};
    endfunction

    function automatic logic [9:0] dutv();
        return {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
                soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    task automatic idle();
        detect_add = 0; data_in = 0; write_enb_reg = 0;
        rd = 0; empty = 3'b111; full = 0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        repeat (3) @(negedge clock);
        #1;
        tests_run++;
        if (dutv() !== 10'b0) begin
            fails++; $display("FAIL reset_outputs got %b want %b", dutv(), 10'b0);
        end
        resetn = 1;
        write_enb_reg = 1;
        #1;
        tests_run++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
            fails++; $display("FAIL reset_wr_invalid got we=%b ff=%b want we=000 ff=0", write_enb, fifo_full);
        end
        @(negedge clock);
        idle();
    endtask

    task automatic test_steering();
        detect_add = 1; data_in = 2'd1;
        @(negedge clock);
        detect_add = 0; data_in = 2'd3;
        write_enb_reg = 1;
        for (int k = 0; k < 15; k++) begin
            #1;
            tests_run++;
            if (write_enb !== 3'b010) begin
                fails++; $display("FAIL steer_we cycle %0d got %b want 010", k, write_enb);
            end
            tests_run++;
            if (dutv() !== expv()) begin
                fails++; $display("FAIL steer_model cycle %0d got %b want %b", k, dutv(), expv());
            end
            @(negedge clock);
        end
        full = 3'b010;
        #1;
        tests_run++;
        if (fifo_full !== 1'b1) begin
            fails++; $display("FAIL steer_full1 got %b want 1", fifo_full);
        end
        full = 3'b001;
        #1;
        tests_run++;
        if (fifo_full !== 1'b0) begin
            fails++; $display("FAIL steer_full0 got %b want 0", fifo_full);
        end
        @(negedge clock);
        idle();
    endtask

    task automatic test_same_cycle();
        detect_add = 1; data_in = 2'd0;
        @(negedge clock);
        detect_add = 1; data_in = 2'd2; write_enb_reg = 1;
        #1;
        tests_run++;
        if (write_enb !== 3'b001) begin
            fails++; $display("FAIL same_cycle_old got %b want 001", write_enb);
        end
        @(negedge clock);
        detect_add = 0;
        #1;
        tests_run++;
        if (write_enb !== 3'b100) begin
            fails++; $display("FAIL same_cycle_new got %b want 100", write_enb);
        end
        @(negedge clock);
        idle();
    endtask

    task automatic test_timeout();
        empty[2] = 0;
        for (int k = 1; k <= 2 * TO + 5; k++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if ({soft_reset_2, soft_reset_1, soft_reset_0} !== {(k % TO == 0), 2'b00}) begin
                fails++; $display("FAIL timeout edge %0d got %b want %b", k,
                    {soft_reset_2, soft_reset_1, soft_reset_0}, {(k % TO == 0), 2'b00});
            end
            tests_run++;
            if (dutv() !== expv()) begin
                fails++; $display("FAIL timeout_model edge %0d got %b want %b", k, dutv(), expv());
            end
        end
        idle();
        @(negedge clock);
    endtask

    task automatic test_restart();
        empty[0] = 0;
        for (int k = 1; k <= 55; k++) begin
            rd[0] = (k == 20);
            @(negedge clock);
            #1;
            tests_run++;
            if (soft_reset_0 !== (k == 50)) begin
                fails++; $display("FAIL restart edge %0d got %b want %b", k, soft_reset_0, (k == 50));
            end
            tests_run++;
            if (dutv() !== expv()) begin
                fails++; $display("FAIL restart_model edge %0d got %b want %b", k, dutv(), expv());
            end
        end
        idle();
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        detect_add = 1; data_in = 2'd1;
        @(negedge clock);
        detect_add = 0;
        empty[1] = 0;
        repeat (24) @(negedge clock);
        resetn = 0;
        @(negedge clock);
        resetn = 1;
        write_enb_reg = 1;
        #1;
        tests_run++;
        if (write_enb !== 3'b000) begin
            fails++; $display("FAIL reset_mid_addr got %b want 000", write_enb);
        end
        for (int k = 1; k <= 35; k++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if (soft_reset_1 !== (k == TO)) begin
                fails++; $display("FAIL reset_mid edge %0d got %b want %b", k, soft_reset_1, (k == TO));
            end
        end
        idle();
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            detect_add    = ($urandom_range(0, 7) == 0);
            data_in       = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            full          = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                rd[i]    = ($urandom_range(0, 44) == 0);
                empty[i] = ($urandom_range(0, 19) == 0);
            end
            resetn = ($urandom_range(0, 299) != 0);
            #1;
            tests_run++;
            if (dutv() !== expv()) begin
                fails++; $display("FAIL random cycle %0d got %b want %b", k, dutv(), expv());
            end
            @(negedge clock);
        end
        resetn = 1;
        idle();
    endtask

    initial begin
        test_reset();
        test_steering();
        test_same_cycle();
        test_timeout();
        test_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
